cam_read: RTL and testbench

CAM_READ -- requirements
Module: cam_read

---
 rtl/cam_read.sv | 133 +++++++++++++
 tb/tb_cam_read.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_read.sv
// OV7670 capture: turns the RGB565 byte stream into RGB332 pixel writes for a
// dual-port frame buffer, framed by vsync and gated per line by href.
module cam_read #(
    parameter int CAM_SCREEN_X = 320,
    parameter int CAM_SCREEN_Y = 240,
    parameter int AW           = 17,
    parameter int DW           = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    CAM_px_data,
    input  logic          CAM_href,
    input  logic          CAM_vsync,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          DP_RAM_regW,
    output logic          frame_done,
    output logic          overflow
);

    typedef enum logic {WAIT_FRAME, CAPTURE} state_t;
    typedef enum logic {BYTE1, BYTE2} phase_t;

    // One extra bit so a buffer exactly 2**AW words deep still compares correctly.
    localparam logic [AW:0] N_PIX = (AW+1)'(CAM_SCREEN_X * CAM_SCREEN_Y);

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic          vsync_prev_q, vsync_prev_d;
    logic [2:0]    r_q, r_d;
    logic [2:0]    g_q, g_d;
    logic [1:0]    b_q, b_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          regw_q, regw_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;

    logic vsync_fall, vsync_rise;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        vsync_prev_d = CAM_vsync;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        addr_d       = addr_q;
        data_d       = data_q;
        regw_d       = 1'b0;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;

        vsync_fall = vsync_prev_q & ~CAM_vsync;
        vsync_rise = ~vsync_prev_q & CAM_vsync;

        // Address advances on the edge that ends a write cycle.
        if (regw_q) begin
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            WAIT_FRAME: begin
                if (vsync_fall) begin
                    state_d    = CAPTURE;
                    addr_d     = '0;
                    phase_d    = BYTE1;
                    overflow_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (!CAM_href) begin
                    phase_d = BYTE1;
                end else if (phase_q == BYTE1) begin
                    r_d     = CAM_px_data[7:5];
                    g_d     = CAM_px_data[2:0];
                    phase_d = BYTE2;
                end else begin
                    b_d     = CAM_px_data[4:3];
                    phase_d = BYTE1;
                    if ({1'b0, addr_q} < N_PIX) begin
                        regw_d = 1'b1;
                        data_d = DW'({r_q, g_q, CAM_px_data[4:3]});
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                // A pixel completed on this same edge is still written next cycle.
                if (vsync_rise) begin
                    frame_done_d = 1'b1;
                    state_d      = WAIT_FRAME;
                    phase_d      = BYTE1;
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_FRAME;
            phase_q      <= BYTE1;
            vsync_prev_q <= 1'b0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            regw_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            vsync_prev_q <= vsync_prev_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            regw_q       <= regw_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign DP_RAM_addr_in = addr_q;
    assign DP_RAM_data_in = data_q;
    assign DP_RAM_regW    = regw_q;
    assign frame_done     = frame_done_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_cam_read.sv
// Directed bench for cam_read on a small 6x4 screen so a full frame,
// overflow and frame-end corner cases fit in a short run.
module tb_cam_read;

    localparam int X   = 6;
    localparam int Y   = 4;
    localparam int NPX = X * Y;
    localparam int AW  = 5;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    camPxData = '0;
    logic          camHref = 1'b0;
    logic          camVsync = 1'b0;
    logic [AW-1:0] ramAddr;
    logic [DW-1:0] ramData;
    logic          ramRegW;
    logic          frameDone;
    logic          overflowFlag;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int fdCount = 0;
    int lastAddr = -1;
    int lastData = -1;

    cam_read #(
        .CAM_SCREEN_X(X),
        .CAM_SCREEN_Y(Y),
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .CAM_px_data(camPxData),
        .CAM_href(camHref),
        .CAM_vsync(camVsync),
        .DP_RAM_addr_in(ramAddr),
        .DP_RAM_data_in(ramData),
        .DP_RAM_regW(ramRegW),
        .frame_done(frameDone),
        .overflow(overflowFlag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vsync;
        logic       href;
        logic [7:0] data;
        logic       expRegW;
        int         expAddr;
        int         expData;
        logic       expFd;
        logic       expOv;
    } vec_t;

    vec_t vecs[17];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one byte slot, clock it, then tally whatever the DUT shows after the edge.
    task automatic applyStimulus(input logic v, input logic h, input logic [7:0] d);
        camVsync  = v;
        camHref   = h;
        camPxData = d;
        @(posedge clk);
        #1;
        if (ramRegW === 1'b1) begin
            writes++;
            lastAddr = int'(ramAddr);
            lastData = int'(ramData);
        end
        if (frameDone === 1'b1) fdCount++;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_addr"}, int'(ramAddr), 0);
        checkOutput({tag, "_data"}, int'(ramData), 0);
        checkOutput({tag, "_regW"}, int'(ramRegW), 0);
        checkOutput({tag, "_fd"}, int'(frameDone), 0);
        checkOutput({tag, "_ov"}, int'(overflowFlag), 0);
    endtask

    task automatic sendPixel(input logic [7:0] b1, input logic [7:0] b2);
        applyStimulus(1'b0, 1'b1, b1);
        applyStimulus(1'b0, 1'b1, b2);
    endtask

    // Full frame of white pixels with line gaps, optionally padded with extra pixels.
    task automatic runFrame(input int extraPixels, input logic expOv);
        applyStimulus(1'b1, 1'b0, 8'h00);
        writes  = 0;
        fdCount = 0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        for (int ln = 0; ln < Y; ln++) begin
            for (int px = 0; px < X; px++) sendPixel(8'hFF, 8'hFF);
            applyStimulus(1'b0, 1'b0, 8'h00);
            applyStimulus(1'b0, 1'b0, 8'h00);
        end
        for (int e = 0; e < extraPixels; e++) sendPixel(8'hFF, 8'hFF);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("frame_writes", writes, NPX);
        checkOutput("frame_last_addr", lastAddr, NPX - 1);
        checkOutput("frame_last_data", lastData, 8'hFF);
        checkOutput("frame_addr_hold", int'(ramAddr), NPX);
        checkOutput("frame_ov", int'(overflowFlag), int'(expOv));
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("frame_done_pulse", int'(frameDone), 1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("frame_done_one_cycle", int'(frameDone), 0);
        checkOutput("frame_done_count", fdCount, 1);
        checkOutput("frame_addr_after", int'(ramAddr), NPX);
        checkOutput("frame_ov_after", int'(overflowFlag), int'(expOv));
    endtask

    initial begin
        // vsync, href, data, regW, addr, data_out, frame_done, overflow
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'hE0, 1'b0, 0, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 0, 8'hE0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1, 8'hE0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h1F, 1'b1, 1, 8'h03, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2, 8'h03, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h07, 1'b0, 2, 8'h03, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'hE0, 1'b1, 2, 8'h1C, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h07, 1'b0, 3, 8'h1C, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 3, 8'h1C, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'hFF, 1'b0, 3, 8'h1C, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'hFF, 1'b1, 3, 8'hFF, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 4, 8'hFF, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 4, 8'hFF, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 8'hFF, 1'b0, 4, 8'hFF, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 8'h00, 1'b0, 4, 8'hFF, 1'b0, 1'b0};

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'hAA);
        checkAllZero("reset");
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].vsync, vecs[i].href, vecs[i].data);
            checkOutput($sformatf("vec%0d_regW", i), int'(ramRegW), int'(vecs[i].expRegW));
            checkOutput($sformatf("vec%0d_addr", i), int'(ramAddr), vecs[i].expAddr);
            if (vecs[i].expRegW) checkOutput($sformatf("vec%0d_data", i), int'(ramData), vecs[i].expData);
            checkOutput($sformatf("vec%0d_fd", i), int'(frameDone), int'(vecs[i].expFd));
            checkOutput($sformatf("vec%0d_ov", i), int'(overflowFlag), int'(vecs[i].expOv));
        end

        $display("[TB] exact full frame");
        runFrame(0, 1'b0);

        $display("[TB] frame with two extra pixels");
        runFrame(2, 1'b1);

        // New frame start clears overflow; then vsync rises on a BYTE2 edge.
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("newframe_ov_clear", int'(overflowFlag), 0);
        checkOutput("newframe_addr", int'(ramAddr), 0);
        applyStimulus(1'b0, 1'b1, 8'hE0);
        applyStimulus(1'b1, 1'b1, 8'h1F);
        checkOutput("coincide_regW", int'(ramRegW), 1);
        checkOutput("coincide_addr", int'(ramAddr), 0);
        checkOutput("coincide_data", int'(ramData), 8'hE3);
        checkOutput("coincide_fd", int'(frameDone), 1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("coincide_regW_after", int'(ramRegW), 0);
        checkOutput("coincide_fd_after", int'(frameDone), 0);
        checkOutput("coincide_addr_after", int'(ramAddr), 1);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 1'b0, 8'h00);
        for (int p = 0; p < 10; p++) sendPixel(8'h55, 8'h55);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h55);
        checkAllZero("midreset");
        rst = 1'b0;
        writes = 0;
        for (int p = 0; p < 20; p++) sendPixel(8'h55, 8'h55);
        checkOutput("postreset_writes", writes, 0);
        checkOutput("postreset_addr", int'(ramAddr), 0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        sendPixel(8'hE0, 8'h00);
        checkOutput("postreset_regW", int'(ramRegW), 1);
        checkOutput("postreset_first_addr", int'(ramAddr), 0);
        checkOutput("postreset_first_data", int'(ramData), 8'hE0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
